uart_tx_ctrl: RTL and testbench

//  Frame controller directly upstream of the UART TX output mux. Accepts a parallel word
//  and sequences one frame: start, DATA_WIDTH data bits LSB-first, optional parity, stop.

---
 rtl/uart_tx_ctrl_pkg.sv | 18 +
 rtl/uart_tx_serializer.sv | 40 ++++
 rtl/uart_tx_ctrl.sv | 88 ++++++++
 tb/tb_uart_tx_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_ctrl_pkg.sv
// Shared encodings for the UART TX frame controller and the downstream TX output mux.
// The mux decodes MUX_SEL with exactly these codes, so they must not change independently.
package uart_tx_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [1:0] START_SEL = 2'b00;
  localparam logic [1:0] DATA_SEL  = 2'b01;
  localparam logic [1:0] PAR_SEL   = 2'b10;
  localparam logic [1:0] STOP_SEL  = 2'b11;

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shift register and bit counter; presents one data bit per clock, LSB first.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ser_data,
  output logic                  ser_done
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CW-1:0]         bit_cnt;

  // Loading clears the counter, so it always starts at zero when DATA is entered;
  // the counter saturates at the last bit instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (load) begin
      shift_reg <= data_in;
      bit_cnt   <= '0;
    end else if (shift_en) begin
      shift_reg <= shift_reg >> 1;
      if (bit_cnt != LAST) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  assign ser_data = shift_reg[0];
  assign ser_done = (bit_cnt == LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX frame sequencer: start, LSB-first data, optional parity, stop; drives the
// select and data inputs of the registered TX output mux (line lags MUX_SEL by one clock).
module uart_tx_ctrl
  import uart_tx_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [1:0]            MUX_SEL,
  output logic                  SER_DATA,
  output logic                  PAR_BIT,
  output logic                  BUSY
);

  state_t state;
  state_t next_state;
  logic   par_en_q;
  logic   accept;
  logic   shift_en;
  logic   ser_done;

  // A new word is only taken while idle or in the stop bit (back-to-back frames).
  assign accept   = DATA_VALID && ((state == IDLE) || (state == STOP));
  assign shift_en = (state == DATA);

  uart_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_serializer (
    .clk     (CLK),
    .rst_n   (RST),
    .load    (accept),
    .shift_en(shift_en),
    .data_in (P_DATA),
    .ser_data(SER_DATA),
    .ser_done(ser_done)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      par_en_q <= 1'b0;
      PAR_BIT  <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        par_en_q <= PAR_EN;
        PAR_BIT  <= PAR_TYP ? ~^P_DATA : ^P_DATA;
      end
    end
  end

  always_comb begin
    next_state = state;
    MUX_SEL    = STOP_SEL;
    BUSY       = 1'b1;
    unique case (state)
      IDLE: begin
        BUSY = 1'b0;
        if (DATA_VALID) next_state = START;
      end
      START: begin
        MUX_SEL    = START_SEL;
        next_state = DATA;
      end
      DATA: begin
        MUX_SEL = DATA_SEL;
        if (ser_done) next_state = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        MUX_SEL    = PAR_SEL;
        next_state = STOP;
      end
      STOP: begin
        next_state = DATA_VALID ? START : IDLE;
      end
      default: begin
        BUSY       = 1'b0;
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: a frame-level reference model predicts the
// per-cycle select, data bit, parity, busy and registered line for a queue of frames.
module tb_uart_tx_ctrl;

  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [DW-1:0] P_DATA = '0;
  logic          DATA_VALID = 1'b0;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic [1:0]    MUX_SEL;
  logic          SER_DATA;
  logic          PAR_BIT;
  logic          BUSY;
  logic          line;

  int errors = 0;
  int checks = 0;

  // Frames to send back to back in the next run_frames call.
  logic [DW-1:0] fq_data[$];
  bit            fq_en[$];
  bit            fq_typ[$];

  // Expected per-cycle trace produced by the model.
  logic [1:0] exp_sel[$];
  bit         exp_ser[$];
  bit         exp_ser_chk[$];
  bit         exp_par[$];
  bit         exp_busy[$];
  bit         exp_line[$];
  int         exp_stop_of[$];

  uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .DATA_VALID(DATA_VALID),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .MUX_SEL   (MUX_SEL),
    .SER_DATA  (SER_DATA),
    .PAR_BIT   (PAR_BIT),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  // Stand-in for the downstream registered TX mux, idle-high.
  always @(posedge CLK or negedge RST) begin
    if (!RST) line <= 1'b1;
    else case (MUX_SEL)
      2'b00:   line <= 1'b0;
      2'b01:   line <= SER_DATA;
      2'b10:   line <= PAR_BIT;
      default: line <= 1'b1;
    endcase
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic push_exp(input logic [1:0] sel, input bit ser, input bit ser_chk,
                          input bit par, input bit busy, input bit ln, input int stop_of);
    exp_sel.push_back(sel);
    exp_ser.push_back(ser);
    exp_ser_chk.push_back(ser_chk);
    exp_par.push_back(par);
    exp_busy.push_back(busy);
    exp_line.push_back(ln);
    exp_stop_of.push_back(stop_of);
  endtask

  task automatic add_frame(input logic [DW-1:0] d, input bit en, input bit typ);
    fq_data.push_back(d);
    fq_en.push_back(en);
    fq_typ.push_back(typ);
  endtask

  task automatic drive_frame(input int f);
    DATA_VALID = 1'b1;
    P_DATA     = fq_data[f];
    PAR_EN     = fq_en[f];
    PAR_TYP    = fq_typ[f];
  endtask

  // junk_mode: 0 = quiet inputs during a frame, 1 = random inputs, 2 = DATA_VALID held
  // high with junk_data on P_DATA. All of it must be ignored mid-frame.
  task automatic run_frames(input int junk_mode, input logic [DW-1:0] junk_data);
    bit p = 1'b0;
    bit prev_line = 1'b1;
    int nf;
    exp_sel.delete(); exp_ser.delete(); exp_ser_chk.delete(); exp_par.delete();
    exp_busy.delete(); exp_line.delete(); exp_stop_of.delete();
    nf = fq_data.size();
    for (int f = 0; f < nf; f++) begin
      p = bit'(($countones(fq_data[f]) % 2) != 0) ^ fq_typ[f];
      push_exp(2'b00, 1'b0, 1'b0, p, 1'b1, 1'b0, -1);
      for (int i = 0; i < DW; i++)
        push_exp(2'b01, fq_data[f][i], 1'b1, p, 1'b1, fq_data[f][i], -1);
      if (fq_en[f]) push_exp(2'b10, 1'b0, 1'b0, p, 1'b1, p, -1);
      push_exp(2'b11, 1'b0, 1'b0, p, 1'b1, 1'b1, f);
    end
    push_exp(2'b11, 1'b0, 1'b0, p, 1'b0, 1'b1, -1);

    @(negedge CLK);
    drive_frame(0);
    for (int k = 0; k < exp_sel.size(); k++) begin
      @(negedge CLK);
      checks++;
      if (MUX_SEL !== exp_sel[k]) begin
        errors++;
        $display("[TB] FAIL mux_sel cycle %0d: got %b expected %b", k, MUX_SEL, exp_sel[k]);
      end
      checks++;
      if (BUSY !== exp_busy[k]) begin
        errors++;
        $display("[TB] FAIL busy cycle %0d: got %b expected %b", k, BUSY, exp_busy[k]);
      end
      checks++;
      if (PAR_BIT !== exp_par[k]) begin
        errors++;
        $display("[TB] FAIL par_bit cycle %0d: got %b expected %b", k, PAR_BIT, exp_par[k]);
      end
      checks++;
      if (line !== prev_line) begin
        errors++;
        $display("[TB] FAIL line cycle %0d: got %b expected %b", k, line, prev_line);
      end
      if (exp_ser_chk[k]) begin
        checks++;
        if (SER_DATA !== exp_ser[k]) begin
          errors++;
          $display("[TB] FAIL ser_data cycle %0d: got %b expected %b", k, SER_DATA, exp_ser[k]);
        end
      end
      prev_line = exp_line[k];

      if (exp_stop_of[k] >= 0 && exp_stop_of[k] + 1 < nf) begin
        drive_frame(exp_stop_of[k] + 1);
      end else if (exp_sel[k] == 2'b11) begin
        DATA_VALID = 1'b0;
        P_DATA     = DW'($urandom);
      end else if (junk_mode == 1) begin
        DATA_VALID = 1'($urandom);
        P_DATA     = DW'($urandom);
        PAR_EN     = 1'($urandom);
        PAR_TYP    = 1'($urandom);
      end else if (junk_mode == 2) begin
        DATA_VALID = 1'b1;
        P_DATA     = junk_data;
        PAR_EN     = ~PAR_EN;
        PAR_TYP    = ~PAR_TYP;
      end else begin
        DATA_VALID = 1'b0;
      end
    end
    DATA_VALID = 1'b0;
    fq_data.delete(); fq_en.delete(); fq_typ.delete();
  endtask

  task automatic test_reset;
    add_frame(8'h01, 1'b1, 1'b0);
    run_frames(0, 8'h00);
    @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    checks++;
    if (MUX_SEL !== 2'b11) begin
      errors++; $display("[TB] FAIL reset mux_sel: got %b expected 11", MUX_SEL);
    end
    checks++;
    if (BUSY !== 1'b0) begin
      errors++; $display("[TB] FAIL reset busy: got %b expected 0", BUSY);
    end
    checks++;
    if (SER_DATA !== 1'b0) begin
      errors++; $display("[TB] FAIL reset ser_data: got %b expected 0", SER_DATA);
    end
    checks++;
    if (PAR_BIT !== 1'b0) begin
      errors++; $display("[TB] FAIL reset par_bit: got %b expected 0", PAR_BIT);
    end
    #1 RST = 1'b1;
  endtask

  task automatic test_a5_even;
    add_frame(8'hA5, 1'b1, 1'b0);
    run_frames(0, 8'h00);
  endtask

  task automatic test_parity;
    add_frame(8'h03, 1'b1, 1'b1);
    run_frames(0, 8'h00);
    add_frame(8'h03, 1'b0, 1'b1);
    run_frames(0, 8'h00);
  endtask

  task automatic test_back_to_back;
    add_frame(8'h55, 1'b0, 1'b0);
    add_frame(8'hFF, 1'b1, 1'b1);
    run_frames(2, 8'hFF);
  endtask

  task automatic test_ignore_busy;
    add_frame(8'h0F, 1'b0, 1'b0);
    run_frames(2, 8'hF0);
  endtask

  task automatic test_mid_frame_reset;
    @(negedge CLK);
    DATA_VALID = 1'b1; P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b1;
    @(negedge CLK);
    DATA_VALID = 1'b0;
    repeat (4) @(negedge CLK);
    checks++;
    if (MUX_SEL !== 2'b01 || SER_DATA !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pre_reset bit3: got sel=%b ser=%b expected sel=01 ser=0", MUX_SEL, SER_DATA);
    end
    #2 RST = 1'b0;
    #1;
    checks++;
    if (MUX_SEL !== 2'b11 || BUSY !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset: got sel=%b busy=%b expected sel=11 busy=0", MUX_SEL, BUSY);
    end
    checks++;
    if (PAR_BIT !== 1'b0 || SER_DATA !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset regs: got par=%b ser=%b expected 0 0", PAR_BIT, SER_DATA);
    end
    #1 RST = 1'b1;
    add_frame(8'h3C, 1'b1, 1'b0);
    run_frames(0, 8'h00);
  endtask

  task automatic test_random;
    for (int r = 0; r < 6; r++) begin
      int n = $urandom_range(1, 3);
      for (int f = 0; f < n; f++)
        add_frame(DW'($urandom), 1'($urandom), 1'($urandom));
      run_frames(1, 8'h00);
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end
  endtask

  initial begin
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    test_reset();
    test_a5_even();
    test_parity();
    test_back_to_back();
    test_ignore_busy();
    test_mid_frame_reset();
    test_random();
    repeat (2) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
